ifetch_queue: RTL and testbench

//  Parametrised instruction fetch unit with an in-order prefetch queue; successor to the single-register fetch stage.

---
 rtl/ifetch_queue_pkg.sv | 15 +
 rtl/ifetch_queue_fifo.sv | 56 +++++
 rtl/ifetch_queue.sv | 96 +++++++++
 tb/tb_ifetch_queue.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_queue_pkg.sv
// Shared defaults and helpers for the instruction fetch queue.
package ifetch_queue_pkg;

   localparam int unsigned DEF_ADDR_W   = 16;
   localparam int unsigned DEF_INST_W   = 32;
   localparam int unsigned DEF_DEPTH    = 4;
   localparam int unsigned DEF_RESET_PC = 0;

   // A queue entry carries the word address alongside the instruction word.
   function automatic int unsigned entry_width(input int unsigned addr_w,
                                               input int unsigned inst_w);
      return addr_w + inst_w;
   endfunction

endpackage

// File: rtl/ifetch_queue_fifo.sv
// In-order prefetch queue: synchronous push/pop, flush clears all entries.
module ifetch_queue_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 48,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Storage needs no reset; only entries covered by count are ever shown.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally at DEPTH; flush wins over any push or pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign dout = mem[rd_ptr];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch unit: PC, issue credit and in-flight tracking in front of
// a prefetch queue, feeding decode through a valid/stall handshake.
module ifetch_queue
   import ifetch_queue_pkg::*;
#(
   parameter int unsigned        ADDR_W   = DEF_ADDR_W,
   parameter int unsigned        INST_W   = DEF_INST_W,
   parameter int unsigned        DEPTH    = DEF_DEPTH,
   parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic [INST_W-1:0] mem_data_i,
   input  logic              branch_i,
   input  logic [ADDR_W-1:0] branch_addr_i,
   input  logic              stall_i,
   output logic              inst_valid_o,
   output logic [INST_W-1:0] inst_o,
   output logic [ADDR_W-1:0] inst_addr_o
);

   localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
   localparam int unsigned ENTRY_W = entry_width(ADDR_W, INST_W);

   logic [ADDR_W-1:0]  pc;
   logic [ADDR_W-1:0]  req_pc;
   logic               run;
   logic               inflight;
   logic [CNT_W-1:0]   count;
   logic [CNT_W:0]     credit;
   logic               pop;
   logic               push;
   logic               issue;
   logic [ENTRY_W-1:0] head;
   logic [ENTRY_W-1:0] last;

   // A branch discards everything: no pop, no capture of the in-flight word.
   assign pop  = inst_valid_o & ~stall_i & ~branch_i;
   assign push = inflight & ~branch_i;

   // Issue only when the queue can absorb this read and the one in flight.
   assign credit = {1'b0, count} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};
   assign issue  = run & ~branch_i & (credit < (CNT_W + 1)'(DEPTH));

   assign mem_req_o  = issue;
   assign mem_addr_o = pc;

   // PC, run flag and the address of the read currently in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc       <= RESET_PC;
         req_pc   <= RESET_PC;
         run      <= 1'b0;
         inflight <= 1'b0;
      end else begin
         run      <= 1'b1;
         inflight <= issue;
         if (branch_i) begin
            pc <= branch_addr_i;
         end else if (issue) begin
            pc     <= pc + ADDR_W'(1);
            req_pc <= pc;
         end
      end
   end

   // Remember the most recently popped entry so the outputs hold when empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last <= '0;
      end else if (pop) begin
         last <= head;
      end
   end

   ifetch_queue_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (branch_i),
      .push  (push),
      .pop   (pop),
      .din   ({req_pc, mem_data_i}),
      .dout  (head),
      .count (count)
   );

   assign inst_valid_o = (count != '0);
   assign inst_addr_o  = inst_valid_o ? head[ENTRY_W-1 -: ADDR_W] : last[ENTRY_W-1 -: ADDR_W];
   assign inst_o       = inst_valid_o ? head[INST_W-1:0]          : last[INST_W-1:0];

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: default instance plus a 4-bit address
// instance for PC wrap-around. Memory returns 32'hA000_0000 + address.
module tb_ifetch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic [31:0] mem_data;
   logic        branch;
   logic [15:0] branch_addr;
   logic        stall;
   logic        inst_valid;
   logic [31:0] inst;
   logic [15:0] inst_addr;

   logic        rst4;
   logic        mem_req4;
   logic [3:0]  mem_addr4;
   logic [31:0] mem_data4;
   logic        inst_valid4;
   logic [31:0] inst4;
   logic [3:0]  inst_addr4;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] exp_addr;

   always #5 clk = ~clk;

   ifetch_queue dut (
      .clk           (clk),
      .rst           (rst),
      .mem_req_o     (mem_req),
      .mem_addr_o    (mem_addr),
      .mem_data_i    (mem_data),
      .branch_i      (branch),
      .branch_addr_i (branch_addr),
      .stall_i       (stall),
      .inst_valid_o  (inst_valid),
      .inst_o        (inst),
      .inst_addr_o   (inst_addr)
   );

   ifetch_queue #(
      .ADDR_W   (4),
      .RESET_PC (4'hE)
   ) dut4 (
      .clk           (clk),
      .rst           (rst4),
      .mem_req_o     (mem_req4),
      .mem_addr_o    (mem_addr4),
      .mem_data_i    (mem_data4),
      .branch_i      (1'b0),
      .branch_addr_i (4'h0),
      .stall_i       (1'b0),
      .inst_valid_o  (inst_valid4),
      .inst_o        (inst4),
      .inst_addr_o   (inst_addr4)
   );

   // 1-cycle synchronous read memory for each instance.
   always @(posedge clk) begin
      mem_data  <= 32'hA000_0000 + {16'h0, mem_addr};
      mem_data4 <= 32'hA000_0000 + {28'h0, mem_addr4};
   end

   task automatic test_reset;
      rst = 1'b1; rst4 = 1'b1; stall = 1'b0; branch = 1'b0; branch_addr = '0;
      repeat (2) @(negedge clk);
      #1;
      n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_valid: got %0h expected 0", inst_valid); end
      n_cmp++; if (inst !== 32'h0) begin n_err++; $display("[TB] FAIL reset_inst: got %0h expected 0", inst); end
      n_cmp++; if (inst_addr !== 16'h0) begin n_err++; $display("[TB] FAIL reset_inst_addr: got %0h expected 0", inst_addr); end
      n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("[TB] FAIL reset_req: got %0h expected 0", mem_req); end
      n_cmp++; if (mem_addr !== 16'h0) begin n_err++; $display("[TB] FAIL reset_mem_addr: got %0h expected 0", mem_addr); end
   endtask

   task automatic test_stream;
      @(negedge clk); rst = 1'b0; #1;
      n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("[TB] FAIL first_cycle_req: got %0h expected 0", mem_req); end
      @(negedge clk); #1;
      n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'h0) begin n_err++; $display("[TB] FAIL first_req: got req=%0h addr=%0h expected req=1 addr=0", mem_req, mem_addr); end
      @(negedge clk); #1;
      n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("[TB] FAIL first_latency: got valid=%0h expected 0", inst_valid); end
      exp_addr = 16'h0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); #1;
         n_cmp++;
         if (inst_valid !== 1'b1 || inst_addr !== exp_addr || inst !== 32'hA000_0000 + {16'h0, exp_addr}) begin
            n_err++;
            $display("[TB] FAIL stream: got valid=%0h addr=%0h inst=%0h expected valid=1 addr=%0h inst=%0h",
                     inst_valid, inst_addr, inst, exp_addr, 32'hA000_0000 + {16'h0, exp_addr});
         end
         exp_addr++;
      end
   endtask

   task automatic test_stall;
      int pops;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); stall = 1'b1; #1;
         n_cmp++;
         if (inst_valid !== 1'b1 || inst_addr !== exp_addr) begin
            n_err++;
            $display("[TB] FAIL stall_hold: got valid=%0h addr=%0h expected valid=1 addr=%0h", inst_valid, inst_addr, exp_addr);
         end
      end
      n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("[TB] FAIL full_no_req: got %0h expected 0", mem_req); end
      @(negedge clk); stall = 1'b0; #1;
      n_cmp++;
      if (mem_req !== 1'b1 || mem_addr !== exp_addr + 16'd4) begin
         n_err++;
         $display("[TB] FAIL stall_resume_req: got req=%0h addr=%0h expected req=1 addr=%0h", mem_req, mem_addr, exp_addr + 16'd4);
      end
      pops = 0;
      for (int i = 0; i < 12; i++) begin
         if (i != 0) begin
            @(negedge clk); #1;
         end
         if (inst_valid === 1'b1) begin
            n_cmp++;
            if (inst_addr !== exp_addr || inst !== 32'hA000_0000 + {16'h0, exp_addr}) begin
               n_err++;
               $display("[TB] FAIL stall_release_order: got addr=%0h inst=%0h expected addr=%0h", inst_addr, inst, exp_addr);
            end
            exp_addr++;
            pops++;
         end
      end
      n_cmp++; if (pops !== 12) begin n_err++; $display("[TB] FAIL stall_release_rate: got %0d pops expected 12", pops); end
   endtask

   task automatic test_branch_full;
      repeat (6) begin
         @(negedge clk); stall = 1'b1;
      end
      @(negedge clk); branch = 1'b1; branch_addr = 16'h0009; #1;
      n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("[TB] FAIL branch_no_req: got %0h expected 0", mem_req); end
      @(negedge clk); branch = 1'b0; stall = 1'b0; #1;
      n_cmp++;
      if (inst_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h0009) begin
         n_err++;
         $display("[TB] FAIL branch_c1: got valid=%0h req=%0h addr=%0h expected valid=0 req=1 addr=9", inst_valid, mem_req, mem_addr);
      end
      @(negedge clk); #1;
      n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("[TB] FAIL branch_c2: got valid=%0h expected 0", inst_valid); end
      @(negedge clk); #1;
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_addr !== 16'h0009 || inst !== 32'hA000_0009) begin
         n_err++;
         $display("[TB] FAIL branch_c3: got valid=%0h addr=%0h inst=%0h expected valid=1 addr=9 inst=a0000009", inst_valid, inst_addr, inst);
      end
      @(negedge clk); #1;
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_addr !== 16'h000A || inst !== 32'hA000_000A) begin
         n_err++;
         $display("[TB] FAIL branch_c4: got valid=%0h addr=%0h inst=%0h expected valid=1 addr=a inst=a000000a", inst_valid, inst_addr, inst);
      end
   endtask

   task automatic test_back_to_back;
      @(negedge clk); branch = 1'b1; branch_addr = 16'h0020; #1;
      n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_first_no_req: got %0h expected 0", mem_req); end
      @(negedge clk); branch_addr = 16'h0040; #1;
      n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_second_no_req: got %0h expected 0", mem_req); end
      @(negedge clk); branch = 1'b0; #1;
      n_cmp++;
      if (inst_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h0040) begin
         n_err++;
         $display("[TB] FAIL b2b_c1: got valid=%0h req=%0h addr=%0h expected valid=0 req=1 addr=40", inst_valid, mem_req, mem_addr);
      end
      @(negedge clk); #1;
      n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_c2: got valid=%0h expected 0", inst_valid); end
      @(negedge clk); #1;
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_addr !== 16'h0040 || inst !== 32'hA000_0040) begin
         n_err++;
         $display("[TB] FAIL b2b_first_head: got valid=%0h addr=%0h inst=%0h expected valid=1 addr=40 inst=a0000040", inst_valid, inst_addr, inst);
      end
      @(negedge clk); #1;
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_addr !== 16'h0041) begin
         n_err++;
         $display("[TB] FAIL b2b_second_head: got valid=%0h addr=%0h expected valid=1 addr=41", inst_valid, inst_addr);
      end
   endtask

   task automatic test_reset_midstream;
      repeat (3) begin
         @(negedge clk); stall = 1'b1;
      end
      rst = 1'b1; #1;
      n_cmp++;
      if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_addr !== 16'h0 || mem_req !== 1'b0 || mem_addr !== 16'h0) begin
         n_err++;
         $display("[TB] FAIL midreset_outputs: got valid=%0h inst=%0h addr=%0h req=%0h mem_addr=%0h expected all 0",
                  inst_valid, inst, inst_addr, mem_req, mem_addr);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0; stall = 1'b0; #1;
      n_cmp++; if (mem_req !== 1'b0 || inst_valid !== 1'b0) begin n_err++; $display("[TB] FAIL midreset_r0: got req=%0h valid=%0h expected 0 0", mem_req, inst_valid); end
      @(negedge clk); #1;
      n_cmp++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h0 || inst_valid !== 1'b0) begin
         n_err++;
         $display("[TB] FAIL midreset_r1: got req=%0h addr=%0h valid=%0h expected req=1 addr=0 valid=0", mem_req, mem_addr, inst_valid);
      end
      @(negedge clk); #1;
      n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("[TB] FAIL midreset_stale: got valid=%0h expected 0", inst_valid); end
      @(negedge clk); #1;
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_addr !== 16'h0 || inst !== 32'hA000_0000) begin
         n_err++;
         $display("[TB] FAIL midreset_restart: got valid=%0h addr=%0h inst=%0h expected valid=1 addr=0 inst=a0000000", inst_valid, inst_addr, inst);
      end
   endtask

   task automatic test_wrap;
      logic [3:0] exp4;
      @(negedge clk); rst4 = 1'b0;
      @(negedge clk); #1;
      n_cmp++;
      if (mem_req4 !== 1'b1 || mem_addr4 !== 4'hE) begin
         n_err++;
         $display("[TB] FAIL wrap_first_req: got req=%0h addr=%0h expected req=1 addr=e", mem_req4, mem_addr4);
      end
      exp4 = 4'hE;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         n_cmp++;
         if (i == 0) begin
            if (inst_valid4 !== 1'b0) begin n_err++; $display("[TB] FAIL wrap_latency: got valid=%0h expected 0", inst_valid4); end
         end else begin
            if (inst_valid4 !== 1'b1 || inst_addr4 !== exp4 || inst4 !== 32'hA000_0000 + {28'h0, exp4}) begin
               n_err++;
               $display("[TB] FAIL wrap_seq: got valid=%0h addr=%0h inst=%0h expected valid=1 addr=%0h inst=%0h",
                        inst_valid4, inst_addr4, inst4, exp4, 32'hA000_0000 + {28'h0, exp4});
            end
            exp4 = exp4 + 4'd1;
         end
      end
   endtask

   // Run every scenario in order, then report.
   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_branch_full();
      test_back_to_back();
      test_reset_midstream();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
